// File: rtl/multi_debounce_toggle.sv
// N-channel switch conditioner: input normalisation, synchronizer, counter debounce,
// press/release pulse generation and a per-channel LED toggle flop.
module multi_debounce_toggle #(
    parameter int NUM_CHANNELS     = 4,
    parameter int DEBOUNCE_LIMIT   = 250000,
    parameter int SYNC_STAGES      = 2,
    parameter bit INPUT_ACTIVE_LOW = 1'b0,
    parameter bit TOGGLE_ON_PRESS  = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CHANNELS-1:0] i_switch,
    output logic [NUM_CHANNELS-1:0] o_debounced,
    output logic [NUM_CHANNELS-1:0] o_rise,
    output logic [NUM_CHANNELS-1:0] o_fall,
    output logic [NUM_CHANNELS-1:0] o_led
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    // Normalised so that 1 always means "pressed" from here on.
    logic [NUM_CHANNELS-1:0] w_norm;
    assign w_norm = INPUT_ACTIVE_LOW ? ~i_switch : i_switch;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_db;
        logic                   r_prev;
        logic                   r_led;
        logic                   w_sync;
        logic                   w_rise;
        logic                   w_fall;
        logic                   w_toggle;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_norm[g]};
            end
        end

        assign w_sync = r_sync[SYNC_STAGES-1];

        // Any return to the accepted level restarts the stability count.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (w_sync != r_db) begin
                if (r_cnt == CNT_MAX) begin
                    r_db  <= w_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_prev <= 1'b0;
            end else begin
                r_prev <= r_db;
            end
        end

        assign w_rise   = r_db & ~r_prev;
        assign w_fall   = ~r_db & r_prev;
        assign w_toggle = TOGGLE_ON_PRESS ? w_rise : w_fall;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_led <= 1'b0;
            end else if (w_toggle) begin
                r_led <= ~r_led;
            end
        end

        assign o_debounced[g] = r_db;
        assign o_rise[g]      = w_rise;
        assign o_fall[g]      = w_fall;
        assign o_led[g]       = r_led;
    end

endmodule

// File: doc/multi_debounce_toggle.md
Name: multi_debounce_toggle

Overview:
- N-channel switch conditioner: per-channel synchronizer, counter-based debounce filter, edge-pulse generator and LED toggle flop.
- Generalises the single-switch debounce + LED-toggle pair into one parametrised block.
- Adds input polarity and toggle-edge selection, plus per-channel press/release pulses.
- Sits between the raw board switch pins and the LED or user logic in the top level.

Parameters:
- NUM_CHANNELS, 4, number of independent switch channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive stable clocks required to accept a new level (>=2).
- SYNC_STAGES, 2, synchronizer flop depth per channel (>=2).
- INPUT_ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; raw input is inverted before synchronizing.
- TOGGLE_ON_PRESS, 0, 1 = LED toggles on press (rise); 0 = LED toggles on release (fall).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_switch  input  NUM_CHANNELS  raw bouncy switch pins, asynchronous to i_clk.
- o_debounced  output  NUM_CHANNELS  filtered, normalised switch state (1 = pressed).
- o_rise  output  NUM_CHANNELS  one-cycle pulse on each accepted press.
- o_fall  output  NUM_CHANNELS  one-cycle pulse on each accepted release.
- o_led  output  NUM_CHANNELS  per-channel toggle state.

Behaviour:
- Reset (async assert, sync-safe deassert at the user's top level):
  - All sync flops, counters and o_debounced clear to 0.
  - The registered previous-state copy, o_rise, o_fall and o_led clear to 0.
  - Reset mid-count discards any partial count.
- Normalisation: norm[i] = i_switch[i] XOR INPUT_ACTIVE_LOW, fed into a SYNC_STAGES flop chain. The last stage is sync[i].
- Counter:
  - Width = $clog2(DEBOUNCE_LIMIT).
  - Each channel owns an independent counter, with no sharing between channels.
- Per-channel filter, each clock:
  - sync != o_debounced and cnt < DEBOUNCE_LIMIT-1: cnt <= cnt+1.
  - sync != o_debounced and cnt == DEBOUNCE_LIMIT-1: o_debounced <= sync, cnt <= 0.
  - sync == o_debounced: cnt <= 0. Any bounce back restarts the count.
- Latency:
  - After a clean level change held stable, o_debounced changes exactly SYNC_STAGES+DEBOUNCE_LIMIT rising edges after the first edge that samples the new pin level.
  - A pulse or glitch shorter than DEBOUNCE_LIMIT synchronized cycles never changes o_debounced.
- Edge pulses:
  - db_prev is a registered copy of o_debounced.
  - o_rise = o_debounced & ~db_prev; o_fall = ~o_debounced & db_prev.
  - Each pulse is high for exactly one clock: the first cycle o_debounced shows the new value.
- LED:
  - On the clock where the selected pulse is high (o_rise if TOGGLE_ON_PRESS, else o_fall), o_led <= ~o_led.
  - o_led is therefore visible one cycle after the pulse.
- Simultaneous events:
  - Channels are fully independent; all channels may change on the same clock.
  - o_rise and o_fall are never both high on one channel.
- No wrap-around: the counter saturates logically because it resets on acceptance, so it never exceeds DEBOUNCE_LIMIT-1.
- Held switch: one pulse per accepted transition. No auto-repeat.

Test Plan (bench uses NUM_CHANNELS=4, DEBOUNCE_LIMIT=4, SYNC_STAGES=2):
1. Reset, then hold i_switch=0000 for 20 clocks -> all outputs 0; o_led=0000 throughout.
2. Raise i_switch[0] and hold -> o_debounced[0]=1 exactly 6 edges later; o_rise[0] high for 1 clock; o_led[0] unchanged. Release and hold -> o_fall[0] pulse 6 edges after release; o_led[0]=1 the next clock.
3. Bounce ch1: 1 for 3 clocks, 0 for 1, 1 for 3, then 0 -> o_debounced[1] stays 0; no pulses.
4. Drive ch2 and ch3 to 1 on the same clock, then release both -> identical timing on both channels; both o_led bits toggle on the same clock; ch0/ch1 undisturbed.
5. INPUT_ACTIVE_LOW=1, TOGGLE_ON_PRESS=1: idle pins 1111, drive ch0 pin to 0 -> o_debounced[0]=1 after 6 edges; o_led[0]=1 one clock after o_rise[0].
6. Assert i_rst_n=0 midway through a ch0 count (cnt=2) with o_led[0]=1 -> all outputs 0 immediately (async). After release with the pin still pressed, a full 6-edge latency is required before o_debounced[0]=1.
